// File: rtl/score_argmax_reader_if.sv
// Read-side FIFO handshake and result bus between score_argmax_reader and its surroundings.
// The slave modport is the reader's view; master is the view of whoever drives the FIFO and start.
interface score_argmax_reader_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
);
    logic             start;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_data;
    logic             busy;
    logic             done;
    logic             result_valid;
    logic [WIDTH-1:0] max_val;
    logic [IDX_W-1:0] max_idx;

    modport slave (
        input  start, fifo_empty, fifo_data,
        output fifo_rd_en, busy, done, result_valid, max_val, max_idx
    );

    modport master (
        output start, fifo_empty, fifo_data,
        input  fifo_rd_en, busy, done, result_valid, max_val, max_idx
    );
endinterface

// File: rtl/score_argmax_reader.sv
// Pops SEQ_LEN scores from a 1-cycle-latency FIFO and reports the largest one and its
// first position in pop order, with a one-cycle done pulse.
module score_argmax_reader #(
    parameter int WIDTH   = 8,
    parameter int SEQ_LEN = 16,
    parameter int IDX_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    score_argmax_reader_if.slave  bus_if
);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] SEQ_LEN_C = CNT_W'(SEQ_LEN);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(SEQ_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] issued_q;
    logic [CNT_W-1:0] consumed_q;
    logic             pend_q;
    logic [WIDTH-1:0] max_val_q;
    logic [IDX_W-1:0] max_idx_q;
    logic             result_valid_q;
    logic             done_q;
    logic             busy_q;
    logic             rd_en;

    // Pop request depends on the live empty flag, so it stays combinational.
    assign rd_en = (state_q == RUN) && !bus_if.fifo_empty && (issued_q < SEQ_LEN_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            issued_q       <= '0;
            consumed_q     <= '0;
            pend_q         <= 1'b0;
            max_val_q      <= '0;
            max_idx_q      <= '0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus_if.start) begin
                        issued_q       <= '0;
                        consumed_q     <= '0;
                        pend_q         <= 1'b0;
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b1;
                        state_q        <= RUN;
                    end
                end
                RUN: begin
                    pend_q <= rd_en;
                    if (rd_en) begin
                        issued_q <= issued_q + 1'b1;
                    end
                    // pend_q marks the cycle in which the FIFO's registered output holds the popped score.
                    if (pend_q) begin
                        consumed_q <= consumed_q + 1'b1;
                        if (consumed_q == '0) begin
                            max_val_q <= bus_if.fifo_data;
                            max_idx_q <= '0;
                        end else if (bus_if.fifo_data > max_val_q) begin
                            max_val_q <= bus_if.fifo_data;
                            max_idx_q <= consumed_q[IDX_W-1:0];
                        end
                        // Leaving on the final capture puts done exactly one cycle after it.
                        if (consumed_q == LAST_C) begin
                            state_q        <= DONE;
                            done_q         <= 1'b1;
                            result_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_if.fifo_rd_en   = rd_en;
    assign bus_if.busy         = busy_q;
    assign bus_if.done         = done_q;
    assign bus_if.result_valid = result_valid_q;
    assign bus_if.max_val      = max_val_q;
    assign bus_if.max_idx      = max_idx_q;
endmodule
